uart_ex: RTL and testbench

Parametrised full-duplex UART, the successor to the fixed 8N1 UART. It adds configurable data width, parity, stop bits and oversampling, plus a run-time baud divisor. The RX path has a 2-FF synchroniser, 3-sample majority voting and separate parity/framing error flags. It sits between the board serial pins and the byte-stream logic, using a valid/ready transmit handshake and a single-cycle receive strobe.

---
 rtl/uart_ex_pkg.sv | 30 +++
 rtl/uart_ex_tick.sv | 33 +++
 rtl/uart_ex.sv | 203 ++++++++++++++++++++
 tb/tb_uart_ex.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ex_pkg.sv
// rtl/uart_ex_pkg.sv - shared state encodings and parity helper for uart_ex
package uart_ex_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Parity bit to put on (or expect from) the line, given the XOR of the data bits.
    function automatic logic parity_bit(input logic data_xor, input int parity);
        return data_xor ^ (parity == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_ex_tick.sv
// rtl/uart_ex_tick.sv - oversampling tick divider, reloaded at each frame start
module uart_ex_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] div_m1;
    logic [DIV_W-1:0] period_m1;
    logic [DIV_W-1:0] cnt;

    // A divisor of 0 behaves as 1, i.e. a tick every cycle.
    assign div_m1 = (div == '0) ? '0 : div - DIV_W'(1);
    assign tick   = en && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            period_m1 <= '0;
            cnt       <= '0;
        end else if (load) begin
            period_m1 <= div_m1;
            cnt       <= div_m1;
        end else if (en) begin
            cnt <= (cnt == '0) ? period_m1 : cnt - DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_ex.sv
// rtl/uart_ex.sv - parametrised full-duplex UART with majority-vote receiver
module uart_ex
    import uart_ex_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic              rx,
    output logic              tx,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_parity_err,
    output logic              rx_frame_err,
    output logic              is_receiving,
    output logic              is_transmitting
);

    localparam int TKW = $clog2(2 * OVERSAMPLE);
    localparam int BCW = $clog2(DATA_W);
    localparam logic [TKW-1:0] TK_BIT_END  = TKW'(OVERSAMPLE - 1);
    localparam logic [TKW-1:0] TK_STOP_END = TKW'(STOP_BITS * OVERSAMPLE - 1);
    localparam logic [TKW-1:0] TK_S0       = TKW'(OVERSAMPLE / 2 - 1);
    localparam logic [TKW-1:0] TK_S1       = TKW'(OVERSAMPLE / 2);
    localparam logic [TKW-1:0] TK_S2       = TKW'(OVERSAMPLE / 2 + 1);
    localparam logic [BCW-1:0] BC_LAST     = BCW'(DATA_W - 1);

    // ---------------- transmitter ----------------
    tx_state_t         tx_state, tx_next;
    logic              tx_tick, tx_fire, tx_bit_done, tx_par;
    logic [TKW-1:0]    tx_tk;
    logic [BCW-1:0]    tx_bc;
    logic [DATA_W-1:0] tx_sh;

    assign tx_fire         = tx_valid && tx_ready;
    assign is_transmitting = (tx_state != TX_IDLE);

    uart_ex_tick #(.DIV_W(DIV_W)) u_tx_tick (
        .clk  (clk),
        .rst  (rst),
        .load (tx_fire),
        .en   (is_transmitting),
        .div  (baud_div),
        .tick (tx_tick)
    );

    always_comb begin
        tx_ready    = (tx_state == TX_IDLE);
        tx_bit_done = tx_tick && (tx_tk == ((tx_state == TX_STOP) ? TK_STOP_END : TK_BIT_END));
        tx_next     = tx_state;
        tx          = 1'b1;
        case (tx_state)
            TX_IDLE:   if (tx_valid) tx_next = TX_START;
            TX_START: begin
                tx = 1'b0;
                if (tx_bit_done) tx_next = TX_DATA;
            end
            TX_DATA: begin
                tx = tx_sh[0];
                if (tx_bit_done && tx_bc == BC_LAST)
                    tx_next = (PARITY == PAR_NONE) ? TX_STOP : TX_PARITY;
            end
            TX_PARITY: begin
                tx = tx_par;
                if (tx_bit_done) tx_next = TX_STOP;
            end
            TX_STOP:   if (tx_bit_done) tx_next = TX_IDLE;
            default:   tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_tk    <= '0;
            tx_bc    <= '0;
            tx_sh    <= '0;
            tx_par   <= 1'b0;
        end else begin
            tx_state <= tx_next;
            if (tx_fire) begin
                tx_sh  <= tx_data;
                tx_par <= parity_bit(^tx_data, PARITY);
                tx_tk  <= '0;
                tx_bc  <= '0;
            end else if (tx_bit_done) begin
                tx_tk <= '0;
                if (tx_state == TX_DATA) begin
                    tx_sh <= tx_sh >> 1;
                    tx_bc <= tx_bc + BCW'(1);
                end
            end else if (tx_tick) begin
                tx_tk <= tx_tk + TKW'(1);
            end
        end
    end

    // ---------------- receiver ----------------
    logic rx_m, rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    rx_state_t         rx_state, rx_next;
    logic              rx_tick, rx_bit_done, rx_sample, rx_decide, rx_vote, rx_par_bit;
    logic [1:0]        rx_votes;
    logic [TKW-1:0]    rx_tk;
    logic [BCW-1:0]    rx_bc;
    logic [DATA_W-1:0] rx_sh;

    assign is_receiving = (rx_state != RX_IDLE);

    uart_ex_tick #(.DIV_W(DIV_W)) u_rx_tick (
        .clk  (clk),
        .rst  (rst),
        .load ((rx_state == RX_IDLE) && !rx_s),
        .en   (is_receiving),
        .div  (baud_div),
        .tick (rx_tick)
    );

    // Two earlier samples are accumulated in rx_votes; the third is rx_s at the decide tick.
    always_comb begin
        rx_bit_done = rx_tick && (rx_tk == TK_BIT_END);
        rx_sample   = rx_tick && (rx_tk == TK_S0 || rx_tk == TK_S1 || rx_tk == TK_S2);
        rx_decide   = rx_tick && (rx_tk == TK_S2);
        rx_vote     = (rx_votes == 2'd2) || (rx_votes == 2'd1 && rx_s);
        rx_next     = rx_state;
        case (rx_state)
            RX_IDLE:      if (!rx_s) rx_next = RX_START;
            RX_START: begin
                if (rx_decide && rx_vote) rx_next = RX_IDLE;
                else if (rx_bit_done)     rx_next = RX_DATA;
            end
            RX_DATA: begin
                if (rx_bit_done && rx_bc == BC_LAST)
                    rx_next = (PARITY == PAR_NONE) ? RX_STOP : RX_PARITY;
            end
            RX_PARITY:    if (rx_bit_done) rx_next = RX_STOP;
            RX_STOP:      if (rx_decide) rx_next = rx_vote ? RX_IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH: if (rx_s) rx_next = RX_IDLE;
            default:      rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state      <= RX_IDLE;
            rx_tk         <= '0;
            rx_bc         <= '0;
            rx_sh         <= '0;
            rx_votes      <= '0;
            rx_par_bit    <= 1'b0;
            rx_valid      <= 1'b0;
            rx_data       <= '0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            rx_state <= rx_next;
            rx_valid <= 1'b0;
            if (rx_state == RX_IDLE) begin
                rx_tk    <= '0;
                rx_bc    <= '0;
                rx_votes <= '0;
            end else if (rx_tick) begin
                rx_tk <= rx_bit_done ? '0 : rx_tk + TKW'(1);
                if (rx_decide)      rx_votes <= '0;
                else if (rx_sample) rx_votes <= rx_votes + {1'b0, rx_s};
                if (rx_bit_done && rx_state == RX_DATA) rx_bc <= rx_bc + BCW'(1);
                if (rx_decide) begin
                    case (rx_state)
                        RX_DATA:   rx_sh <= {rx_vote, rx_sh[DATA_W-1:1]};
                        RX_PARITY: rx_par_bit <= rx_vote;
                        RX_STOP: begin
                            rx_valid      <= 1'b1;
                            rx_data       <= rx_sh;
                            rx_frame_err  <= !rx_vote;
                            rx_parity_err <= (PARITY != PAR_NONE) &&
                                             (rx_par_bit != parity_bit(^rx_sh, PARITY));
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_ex.sv
// tb/tb_uart_ex.sv - self-checking bench for uart_ex (8N1, 7E2 loopback, 8O1 receive)
module tb_uart_ex;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    logic run_chk = 1'b0;

    // instance a: 8N1
    logic [15:0] div_a = 16'd4;
    logic        rx_a = 1'b1, tx_valid_a = 1'b0;
    logic [7:0]  tx_data_a = '0;
    logic        tx_a, tx_ready_a, rx_valid_a, rx_perr_a, rx_ferr_a, is_rx_a, is_tx_a;
    logic [7:0]  rx_data_a;
    // instance b: 7E2, tx looped to rx
    logic [15:0] div_b = 16'd0;
    logic        tx_valid_b = 1'b0;
    logic [6:0]  tx_data_b = '0;
    logic        tx_b, tx_ready_b, rx_valid_b, rx_perr_b, rx_ferr_b, is_rx_b, is_tx_b;
    logic [6:0]  rx_data_b;
    // instance c: 8O1, receive only
    logic [15:0] div_c = 16'd2;
    logic        rx_c = 1'b1, tx_valid_c = 1'b0;
    logic [7:0]  tx_data_c = '0;
    logic        tx_c, tx_ready_c, rx_valid_c, rx_perr_c, rx_ferr_c, is_rx_c, is_tx_c;
    logic [7:0]  rx_data_c;

    uart_ex #(.DATA_W(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16), .DIV_W(16)) u_a (
        .clk(clk), .rst(rst), .baud_div(div_a), .rx(rx_a), .tx(tx_a),
        .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .tx_data(tx_data_a),
        .rx_valid(rx_valid_a), .rx_data(rx_data_a), .rx_parity_err(rx_perr_a),
        .rx_frame_err(rx_ferr_a), .is_receiving(is_rx_a), .is_transmitting(is_tx_a));

    uart_ex #(.DATA_W(7), .PARITY(2), .STOP_BITS(2), .OVERSAMPLE(16), .DIV_W(16)) u_b (
        .clk(clk), .rst(rst), .baud_div(div_b), .rx(tx_b), .tx(tx_b),
        .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .tx_data(tx_data_b),
        .rx_valid(rx_valid_b), .rx_data(rx_data_b), .rx_parity_err(rx_perr_b),
        .rx_frame_err(rx_ferr_b), .is_receiving(is_rx_b), .is_transmitting(is_tx_b));

    uart_ex #(.DATA_W(8), .PARITY(1), .STOP_BITS(1), .OVERSAMPLE(16), .DIV_W(16)) u_c (
        .clk(clk), .rst(rst), .baud_div(div_c), .rx(rx_c), .tx(tx_c),
        .tx_valid(tx_valid_c), .tx_ready(tx_ready_c), .tx_data(tx_data_c),
        .rx_valid(rx_valid_c), .rx_data(rx_data_c), .rx_parity_err(rx_perr_c),
        .rx_frame_err(rx_ferr_c), .is_receiving(is_rx_c), .is_transmitting(is_tx_c));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line model for instance a: ph_a counts cycles since the accepted word, 0 when idle.
    int         ph_a = 0;
    int         per_a = 64;
    logic [9:0] frm_a = '1;

    always @(posedge clk) begin
        if (rst) begin
            ph_a <= 0;
        end else if (ph_a == 0) begin
            if (tx_valid_a) begin
                ph_a  <= 1;
                per_a <= 16 * ((div_a == 16'd0) ? 1 : int'(div_a));
                frm_a <= {1'b1, tx_data_a, 1'b0};
            end
        end else if (ph_a == 10 * per_a) begin
            ph_a <= 0;
        end else begin
            ph_a <= ph_a + 1;
        end
    end

    function automatic logic exp_tx_a();
        if (ph_a == 0) return 1'b1;
        return frm_a[(ph_a - 1) / per_a];
    endfunction

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    exp_t e;

    always @(negedge clk) begin
        if (run_chk) begin
            check("a_tx", 32'(tx_a), 32'(exp_tx_a()));
            check("a_tx_ready", 32'(tx_ready_a), 32'(ph_a == 0));
            check("a_is_transmitting", 32'(is_tx_a), 32'(ph_a != 0));
            check("c_tx_side_idle", 32'({tx_c, tx_ready_c, is_tx_c}), 32'(3'b110));
            if (rx_valid_a) begin
                if (q_a.size() == 0) check("a_rx_strobe_unexpected", 32'(rx_valid_a), 32'd0);
                else begin
                    e = q_a.pop_front();
                    check("a_rx_data", 32'(rx_data_a), 32'(e.d));
                    check("a_rx_parity_err", 32'(rx_perr_a), 32'(e.pe));
                    check("a_rx_frame_err", 32'(rx_ferr_a), 32'(e.fe));
                end
            end
            if (rx_valid_b) begin
                if (q_b.size() == 0) check("b_rx_strobe_unexpected", 32'(rx_valid_b), 32'd0);
                else begin
                    e = q_b.pop_front();
                    check("b_rx_data", 32'(rx_data_b), 32'(e.d));
                    check("b_rx_parity_err", 32'(rx_perr_b), 32'(e.pe));
                    check("b_rx_frame_err", 32'(rx_ferr_b), 32'(e.fe));
                end
            end
            if (rx_valid_c) begin
                if (q_c.size() == 0) check("c_rx_strobe_unexpected", 32'(rx_valid_c), 32'd0);
                else begin
                    e = q_c.pop_front();
                    check("c_rx_data", 32'(rx_data_c), 32'(e.d));
                    check("c_rx_parity_err", 32'(rx_perr_c), 32'(e.pe));
                    check("c_rx_frame_err", 32'(rx_ferr_c), 32'(e.fe));
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends one word on instance a and measures how long tx_ready stays low and tx stays low.
    task automatic send_a(input logic [7:0] d, output int busy, output int low);
        busy = 0;
        low  = 0;
        tx_data_a  = d;
        tx_valid_a = 1'b1;
        cyc(1);
        tx_valid_a = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (tx_ready_a) break;
            busy++;
            if (!tx_a) low++;
        end
        cyc(1);
    endtask

    task automatic send_serial(input bit to_c, input logic [15:0] bits, input int nbits, input int per);
        for (int i = 0; i < nbits; i++) begin
            if (to_c) rx_c = bits[i];
            else      rx_a = bits[i];
            cyc(per);
        end
        rx_c = 1'b1;
        rx_a = 1'b1;
    endtask

    task automatic drain(input int which, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (which == 0 && q_a.size() == 0) break;
            if (which == 1 && q_b.size() == 0) break;
            if (which == 2 && q_c.size() == 0) break;
            cyc(1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic [6:0] words_b [3];
    int busy, low;

    initial begin
        words_b[0] = 7'h55;
        words_b[1] = 7'h00;
        words_b[2] = 7'h7F;
        cyc(3);
        @(negedge clk);
        check("rst_tx_lines", 32'({tx_a, tx_ready_a, tx_b, tx_ready_b}), 32'(4'hF));
        check("rst_busy_flags", 32'({is_rx_a, is_tx_a, is_rx_b, is_tx_b, is_rx_c, is_tx_c}), 32'd0);
        check("rst_rx_strobes", 32'({rx_valid_a, rx_valid_b, rx_valid_c}), 32'd0);
        check("rst_rx_data", 32'({rx_data_a, rx_data_b, rx_data_c}), 32'd0);
        check("rst_err_flags", 32'({rx_perr_a, rx_ferr_a, rx_perr_b, rx_ferr_b, rx_perr_c, rx_ferr_c}), 32'd0);
        cyc(1);
        rst = 1'b0;
        run_chk = 1'b1;
        cyc(2);

        // 8N1 0xA5 at baud_div 4
        send_a(8'hA5, busy, low);
        check("a_frame_model_a5", 32'(frm_a), 32'(10'b1_10100101_0));
        check("a_a5_busy_cycles", busy, 640);
        check("a_a5_low_cycles", low, 320);

        // reset during data bit 3 of 0xC3
        tx_data_a  = 8'hC3;
        tx_valid_a = 1'b1;
        cyc(1);
        tx_valid_a = 1'b0;
        for (int i = 0; i < 2000 && ph_a != 4 * 64 + 1; i++) cyc(1);
        check("a_reached_bit3", ph_a, 257);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        @(negedge clk);
        check("a_after_rst", 32'({tx_a, tx_ready_a, is_tx_a}), 32'(3'b110));
        cyc(1);
        send_a(8'h81, busy, low);
        check("a_81_busy_cycles", busy, 640);
        check("a_81_low_cycles", low, 448);

        // 7E2 loopback, baud_div 0, three words back to back
        tx_valid_b = 1'b1;
        for (int w = 0; w < 3; w++) begin
            tx_data_b = words_b[w];
            q_b.push_back({2'b00, words_b[w], 1'b0, 1'b0});
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                if (tx_ready_b) break;
            end
            cyc(1);
        end
        tx_valid_b = 1'b0;
        drain(1, 2000);
        check("b_strobes_outstanding", q_b.size(), 0);
        cyc(40);
        check("b_idle_after", 32'({is_rx_b, is_tx_b}), 32'd0);

        // 8O1 receive, baud_div 2: good parity, flipped parity, and a second good word
        q_c.push_back({9'h03C, 1'b0, 1'b0});
        send_serial(1'b1, {5'd0, 1'b1, 1'b1, 8'h3C, 1'b0}, 11, 32);
        q_c.push_back({9'h03C, 1'b1, 1'b0});
        send_serial(1'b1, {5'd0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11, 32);
        q_c.push_back({9'h001, 1'b0, 1'b0});
        send_serial(1'b1, {5'd0, 1'b1, 1'b0, 8'h01, 1'b0}, 11, 32);
        drain(2, 200);
        check("c_strobes_outstanding", q_c.size(), 0);

        // break on instance a: low for 12 bit periods, then a normal frame
        q_a.push_back({9'h000, 1'b0, 1'b1});
        rx_a = 1'b0;
        cyc(12 * 64);
        rx_a = 1'b1;
        cyc(3 * 64);
        check("a_break_strobes_outstanding", q_a.size(), 0);
        check("a_break_released", 32'(is_rx_a), 32'd0);
        q_a.push_back({9'h05A, 1'b0, 1'b0});
        send_serial(1'b0, {6'd0, 1'b1, 8'h5A, 1'b0}, 10, 64);
        drain(0, 200);
        check("a_after_break_outstanding", q_a.size(), 0);

        // 5-cycle glitch at baud_div 4: start is rejected
        cyc(64);
        rx_a = 1'b0;
        cyc(5);
        rx_a = 1'b1;
        cyc(5);
        check("a_glitch_seen", 32'(is_rx_a), 32'd1);
        cyc(100);
        check("a_glitch_rejected", 32'(is_rx_a), 32'd0);
        check("a_glitch_no_error", 32'({rx_perr_a, rx_ferr_a}), 32'd0);
        cyc(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
